// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem request, held instruction, next-PC
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_valid_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic        jump_i,
  input  logic        zero_i,
  input  logic [31:0] imm_i,
  output logic        err_o,
  output logic [31:0] instr_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;

  logic        take_offset;
  logic [31:0] target;

  // Next PC for the held instruction; jump wins over a taken branch, both use the offset
  always_comb begin
    take_offset = jump_i | (branch_i & zero_i);
    target      = pc_q + (take_offset ? imm_i : 32'd4);
  end

  // Next-state and datapath update for the fetch FSM
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    err_d    = err_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid_i) begin
          instr_d  = imem_rdata_i;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready_i) begin
          count_d = count_q + 32'd1;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (target[1:0] != 2'b00) begin
            // Misaligned target: keep the last good PC and park until reset
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            pc_d    = target;
            state_d = S_FETCH;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any outstanding fetch
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Outputs; opcode is gated so the decoder sees all-zero controls when nothing is held
  always_comb begin
    imem_req_o    = (state_q == S_FETCH);
    imem_addr_o   = pc_q;
    instr_valid_o = valid_q;
    instr_o       = instr_q;
    opcode_o      = valid_q ? instr_q[6:0] : 7'b000_0000;
    pc_o          = pc_out_q;
    err_o         = err_q;
    instr_count_o = count_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with cycle-level reference model
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        imem_valid_i = 1'b0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [31:0] pc_o;
  logic        branch_i = 1'b0;
  logic        jump_i = 1'b0;
  logic        zero_i = 1'b0;
  logic [31:0] imm_i = 32'h0;
  logic        err_o;
  logic [31:0] instr_count_o;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .imem_valid_i(imem_valid_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .opcode_o(opcode_o), .pc_o(pc_o),
    .branch_i(branch_i), .jump_i(jump_i), .zero_i(zero_i), .imm_i(imm_i),
    .err_o(err_o), .instr_count_o(instr_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the fetch stage should be holding, from the behavioural rules
  bit          m_starting = 1'b1;
  bit          m_holding  = 1'b0;
  bit          m_broken   = 1'b0;
  logic [31:0] m_pc       = RESET_PC;
  logic [31:0] m_word     = NOP_INSTR;
  logic [31:0] m_word_pc  = RESET_PC;
  logic [31:0] m_consumed = 32'd0;

  always @(posedge clk_i) begin
    logic [31:0] tgt;
    if (rst_i) begin
      m_starting = 1'b1; m_holding = 1'b0; m_broken = 1'b0;
      m_pc = RESET_PC; m_word = NOP_INSTR; m_word_pc = RESET_PC; m_consumed = 0;
    end else if (m_starting) begin
      m_starting = 1'b0;
    end else if (m_broken) begin
      // parked until reset
    end else if (!m_holding) begin
      if (imem_valid_i) begin
        m_holding = 1'b1; m_word = imem_rdata_i; m_word_pc = m_pc;
      end
    end else if (instr_ready_i) begin
      m_consumed = m_consumed + 1;
      tgt = (jump_i || (branch_i && zero_i)) ? m_pc + imm_i : m_pc + 32'd4;
      m_holding = 1'b0;
      m_word = NOP_INSTR;
      if (tgt % 4 != 0) m_broken = 1'b1;
      else m_pc = tgt;
    end
    #1;
    chk("imem_req", {31'd0, imem_req_o}, {31'd0, !m_starting && !m_holding && !m_broken});
    chk("imem_addr", imem_addr_o, m_pc);
    chk("instr_valid", {31'd0, instr_valid_o}, {31'd0, m_holding});
    chk("instr", instr_o, m_word);
    chk("opcode", {25'd0, opcode_o}, m_holding ? {25'd0, m_word[6:0]} : 32'd0);
    chk("pc_o", pc_o, m_word_pc);
    chk("err", {31'd0, err_o}, {31'd0, m_broken});
    chk("count", instr_count_o, m_consumed);
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req_o && n < 40) begin @(negedge clk_i); n++; end
    if (!imem_req_o) begin
      n_vec++; n_err++;
      $display("FAIL wait_req: timed out, req=%0d", imem_req_o);
    end
  endtask

  // One instruction: respond after lat wait cycles, consume rdly cycles after valid
  task automatic do_instr(input int lat, input int rdly, input logic [31:0] word,
                          input logic b, input logic j, input logic z, input logic [31:0] imm);
    int n = 0;
    wait_req();
    repeat (lat) begin imem_rdata_i = $urandom; @(negedge clk_i); end
    imem_valid_i = 1'b1; imem_rdata_i = word;
    @(negedge clk_i);
    imem_valid_i = 1'b0; imem_rdata_i = $urandom;
    while (!instr_valid_o && n < 40) begin @(negedge clk_i); n++; end
    if (!instr_valid_o) begin
      n_vec++; n_err++;
      $display("FAIL wait_valid: timed out, valid=%0d", instr_valid_o);
    end
    repeat (rdly) begin
      branch_i = $urandom; jump_i = $urandom; zero_i = $urandom; imm_i = $urandom;
      @(negedge clk_i);
    end
    instr_ready_i = 1'b1; branch_i = b; jump_i = j; zero_i = z; imm_i = imm;
    @(negedge clk_i);
    instr_ready_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0; zero_i = 1'b0; imm_i = 32'h0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    rst_i = 1'b0;

    // zero-wait memory, ready immediately: addresses 0,4,8
    for (int i = 0; i < 3; i++) do_instr(0, 0, 32'h0000_0033, 0, 0, 0, 32'h0);
    chk("seq_count", instr_count_o, 32'd3);
    chk("seq_addr", imem_addr_o, 32'h0000_000C);

    // slow memory and slow consumer
    do_instr(3, 2, 32'h00A0_0093, 0, 0, 0, 32'h0);
    chk("slow_count", instr_count_o, 32'd4);
    chk("slow_addr", imem_addr_o, 32'h0000_0010);

    // branch taken, not taken, jump
    do_instr(0, 0, 32'h0000_0063, 1, 0, 1, 32'hFFFF_FFF8);
    chk("br_taken", imem_addr_o, 32'h0000_0008);
    do_instr(1, 0, 32'h0000_0033, 0, 0, 0, 32'h0);
    do_instr(0, 1, 32'h0000_0033, 0, 0, 0, 32'h0);
    do_instr(0, 0, 32'h0000_0063, 1, 0, 0, 32'hFFFF_FFF8);
    chk("br_not_taken", imem_addr_o, 32'h0000_0014);
    do_instr(0, 0, 32'h0000_006F, 0, 1, 0, 32'hFFFF_FFFC);
    do_instr(2, 0, 32'h0000_006F, 1, 1, 0, 32'h0000_0100);
    chk("jump", imem_addr_o, 32'h0000_0110);
    do_instr(0, 0, 32'h0000_006F, 0, 1, 0, 32'hFFFF_FF10);
    chk("jump_back", imem_addr_o, 32'h0000_0020);

    // misaligned jump target
    do_instr(0, 0, 32'h0000_006F, 0, 1, 0, 32'h0000_0006);
    chk("err_set", {31'd0, err_o}, 32'd1);
    chk("err_pc_o", pc_o, 32'h0000_0020);
    chk("err_count", instr_count_o, 32'd12);
    instr_ready_i = 1'b1; imem_valid_i = 1'b1; imem_rdata_i = 32'h1234_5677;
    repeat (5) @(negedge clk_i);
    instr_ready_i = 1'b0; imem_valid_i = 1'b0;
    chk("err_stuck_req", {31'd0, imem_req_o}, 32'd0);
    chk("err_stuck_count", instr_count_o, 32'd12);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("err_cleared", {31'd0, err_o}, 32'd0);
    rst_i = 1'b0;

    // reset during a fetch wait, stale response through reset and idle
    wait_req();
    @(negedge clk_i);
    rst_i = 1'b1; imem_valid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    imem_valid_i = 1'b0;
    chk("abort_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("abort_addr", imem_addr_o, 32'h0);
    chk("abort_count", instr_count_o, 32'd0);

    // wrap of the sequential PC
    do_instr(1, 0, 32'h0000_006F, 0, 1, 0, 32'hFFFF_FFFC);
    chk("wrap_pre", imem_addr_o, 32'hFFFF_FFFC);
    do_instr(0, 0, 32'h0000_0033, 0, 0, 0, 32'h0);
    chk("wrap_addr", imem_addr_o, 32'h0000_0000);
    chk("wrap_count", instr_count_o, 32'd2);

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the control decoder.
- Holds the PC and issues requests to instruction memory, which may take a variable number of cycles to respond.
- Presents one fetched instruction at a time to the decode/execute path using a valid/ready handshake.
- Computes the next PC (sequential, branch or jump) from the control and flag signals returned when the instruction is consumed.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_o whenever no valid instruction is held (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  32  fetch address; equals the internal PC.
- imem_rdata_i  in  32  instruction word from memory.
- imem_valid_i  in  1  imem_rdata_i is valid this cycle.
- instr_valid_o  out  1  instr_o/pc_o hold a fetched instruction.
- instr_ready_i  in  1  downstream consumes the held instruction this cycle.
- instr_o  out  32  held instruction word.
- opcode_o  out  7  instr_o[6:0] when instr_valid_o=1, else 7'b0000000.
- pc_o  out  32  PC of the held instruction.
- branch_i  in  1  held instruction is a branch (decoder branch output).
- jump_i  in  1  held instruction is a jump (decoder jump output).
- zero_i  in  1  ALU zero flag for the held instruction.
- imm_i  in  32  sign-extended PC-relative offset for the held instruction.
- err_o  out  1  sticky misaligned-target error.
- instr_count_o  out  32  number of instructions consumed since reset.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, pc=RESET_PC, imem_req_o=0, instr_valid_o=0.
  - instr_o=NOP_INSTR, opcode_o=0, pc_o=RESET_PC, err_o=0, instr_count_o=0.
  - A reset in any state, including mid-wait, aborts the outstanding fetch. No stale response is accepted after reset.
- IDLE:
  - Lasts exactly one cycle after reset deasserts, then moves to FETCH.
- FETCH:
  - imem_req_o=1 and imem_addr_o=pc. The address stays stable until the response arrives.
  - When imem_valid_i=1: register imem_rdata_i into instr_o, set pc_o=pc, assert instr_valid_o and go to HOLD.
  - Latency is therefore response cycle +1. With zero-wait memory (valid in the first FETCH cycle), instr_valid_o rises on the next edge.
- HOLD:
  - imem_req_o=0. instr_o, pc_o and instr_valid_o are held stable until instr_ready_i=1.
  - On the consume edge, compute the target and increment instr_count_o (wraps from 2^32-1 to 0).
  - The target is pc+imm_i if jump_i=1 or (branch_i=1 and zero_i=1); otherwise it is pc+4. All additions are modulo 2^32.
  - branch_i, jump_i, zero_i and imm_i are sampled only on the consume edge and are don't-care otherwise.
  - If target[1:0]!=0, set err_o=1 and go to ERR. Otherwise load pc=target, clear instr_valid_o (instr_o returns to NOP_INSTR) and go to FETCH.
  - Back-to-back throughput is therefore at best one instruction every 2 cycles.
- ERR:
  - imem_req_o=0, instr_valid_o=0 and err_o=1.
  - pc keeps the last good PC (pc_o unchanged).
  - The state is exited only by reset.
- imem_valid_i is ignored in IDLE, HOLD and ERR.
- instr_ready_i is ignored when instr_valid_o=0.
- jump_i takes priority; branch_i and jump_i both high behaves as a jump.
- opcode_o is gated to 0 whenever instr_valid_o=0, so the decoder takes its all-zero default controls.

Test Plan:
- Reset with RESET_PC=0 and zero-wait memory returning 32'h0000_0033, ready held high -> imem_addr_o sequence 0,4,8. instr_valid_o pulses every 2nd cycle. opcode_o=7'b0110011 when valid and 0 otherwise. instr_count_o=3 after the third consume.
- Memory responds 3 cycles after request, and ready is delayed 2 cycles after valid -> imem_addr_o stable throughout the wait. instr_o/pc_o stable during HOLD. Only one increment of instr_count_o per instruction.
- At pc=0x10: branch_i=1, zero_i=1, imm_i=0xFFFF_FFF8 -> next fetch at 0x08. The same instruction with zero_i=0 -> next fetch at 0x14. jump_i=1, imm_i=0x100 -> next fetch at 0x110.
- At pc=0x20: jump_i=1, imm_i=0x6 -> err_o=1, no further imem_req_o, pc_o stays 0x20. A later instr_ready_i or imem_valid_i causes no change; rst_i clears the error.
- rst_i asserted during FETCH wait, and imem_valid_i arrives while in reset or IDLE -> the response is ignored. Fetch restarts at RESET_PC with instr_count_o=0.
- With pc=0xFFFF_FFFC, a sequential consume -> next fetch address wraps to 0x0000_0000.
